// File: rtl/img_spike_streamer.sv
// img_spike_streamer: snapshots an assembled MNIST frame on a start strobe,
// raster-scans it one pixel per clock and emits one address event
// (row, col, index) per set pixel over a valid/ready handshake.
// Reports the accepted spike count and pulses oDONE at end of frame.
// Optional feature macro: IMG_STREAM_LAST_EN adds oEVT_LAST, which is high on
// the final event of the frame (no set pixel above oEVT_INDEX).
module img_spike_streamer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int IDX_W = 10,
    localparam int IMG_BITS = IMG_W * IMG_H
) (
    input  logic                iCLK,
    input  logic                iRESETn,
    input  logic [IMG_BITS-1:0] iIMAGE,
    input  logic                iSTART,
    output logic                oBUSY,
    output logic                oEVT_VALID,
    input  logic                iEVT_READY,
    output logic [4:0]          oEVT_ROW,
    output logic [4:0]          oEVT_COL,
    output logic [IDX_W-1:0]    oEVT_INDEX,
    output logic [IDX_W-1:0]    oSPIKE_COUNT,
    output logic                oDONE
`ifdef IMG_STREAM_LAST_EN
    ,
    output logic                oEVT_LAST
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_r, state_s;

    // The shadow frame is shifted right as the scan advances, so bit 0 is
    // always the pixel under examination and the upper bits are exactly the
    // pixels still to be scanned.
    logic [IMG_BITS-1:0] shadow_r, shadow_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [4:0]          row_r, row_s;
    logic [4:0]          col_r, col_s;

    logic                busy_r, busy_s;
    logic                valid_r, valid_s;
    logic [4:0]          evt_row_r, evt_row_s;
    logic [4:0]          evt_col_r, evt_col_s;
    logic [IDX_W-1:0]    evt_idx_r, evt_idx_s;
    logic [IDX_W-1:0]    count_r, count_s;
    logic                done_r, done_s;
`ifdef IMG_STREAM_LAST_EN
    logic                last_r, last_s;
`endif

    logic                is_last_s;
    logic                col_wrap_s;
    logic [4:0]          col_inc_s;
    logic [4:0]          row_inc_s;

    assign is_last_s  = (idx_r == IDX_W'(IMG_BITS - 1));
    assign col_wrap_s = (col_r == 5'(IMG_W - 1));
    assign col_inc_s  = col_wrap_s ? 5'd0 : (col_r + 5'd1);
    assign row_inc_s  = col_wrap_s ? (row_r + 5'd1) : row_r;

    // State register and all registered outputs/datapath, synchronous reset.
    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            state_r   <= IDLE;
            shadow_r  <= {IMG_BITS{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            row_r     <= 5'd0;
            col_r     <= 5'd0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            evt_row_r <= 5'd0;
            evt_col_r <= 5'd0;
            evt_idx_r <= {IDX_W{1'b0}};
            count_r   <= {IDX_W{1'b0}};
            done_r    <= 1'b0;
`ifdef IMG_STREAM_LAST_EN
            last_r    <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            shadow_r  <= shadow_s;
            idx_r     <= idx_s;
            row_r     <= row_s;
            col_r     <= col_s;
            busy_r    <= busy_s;
            valid_r   <= valid_s;
            evt_row_r <= evt_row_s;
            evt_col_r <= evt_col_s;
            evt_idx_r <= evt_idx_s;
            count_r   <= count_s;
            done_r    <= done_s;
`ifdef IMG_STREAM_LAST_EN
            last_r    <= last_s;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (iSTART) state_s = SCAN;
                else        state_s = IDLE;
            end
            SCAN: begin
                if (shadow_r[0])    state_s = EMIT;
                else if (is_last_s) state_s = DONE;
                else                state_s = SCAN;
            end
            EMIT: begin
                if (iEVT_READY) state_s = is_last_s ? DONE : SCAN;
                else            state_s = EMIT;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and scan counters.
    always_comb begin
        shadow_s  = shadow_r;
        idx_s     = idx_r;
        row_s     = row_r;
        col_s     = col_r;
        busy_s    = busy_r;
        valid_s   = valid_r;
        evt_row_s = evt_row_r;
        evt_col_s = evt_col_r;
        evt_idx_s = evt_idx_r;
        count_s   = count_r;
        done_s    = 1'b0;
`ifdef IMG_STREAM_LAST_EN
        last_s    = last_r;
`endif
        case (state_r)
            IDLE: begin
                if (iSTART) begin
                    shadow_s = iIMAGE;
                    idx_s    = {IDX_W{1'b0}};
                    row_s    = 5'd0;
                    col_s    = 5'd0;
                    count_s  = {IDX_W{1'b0}};
                    busy_s   = 1'b1;
                end else begin
                    busy_s   = 1'b0;
                end
            end
            SCAN: begin
                if (shadow_r[0]) begin
                    valid_s   = 1'b1;
                    evt_row_s = row_r;
                    evt_col_s = col_r;
                    evt_idx_s = idx_r;
`ifdef IMG_STREAM_LAST_EN
                    last_s    = (shadow_r[IMG_BITS-1:1] == {(IMG_BITS-1){1'b0}});
`endif
                end else if (!is_last_s) begin
                    shadow_s = {1'b0, shadow_r[IMG_BITS-1:1]};
                    idx_s    = idx_r + IDX_W'(1);
                    row_s    = row_inc_s;
                    col_s    = col_inc_s;
                end else begin
                    done_s   = 1'b1;
                end
            end
            EMIT: begin
                if (iEVT_READY) begin
                    valid_s = 1'b0;
                    count_s = count_r + IDX_W'(1);
                    if (!is_last_s) begin
                        shadow_s = {1'b0, shadow_r[IMG_BITS-1:1]};
                        idx_s    = idx_r + IDX_W'(1);
                        row_s    = row_inc_s;
                        col_s    = col_inc_s;
                    end else begin
                        done_s   = 1'b1;
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            DONE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s  = 1'b0;
                valid_s = 1'b0;
            end
        endcase
    end

    assign oBUSY        = busy_r;
    assign oEVT_VALID   = valid_r;
    assign oEVT_ROW     = evt_row_r;
    assign oEVT_COL     = evt_col_r;
    assign oEVT_INDEX   = evt_idx_r;
    assign oSPIKE_COUNT = count_r;
    assign oDONE        = done_r;
`ifdef IMG_STREAM_LAST_EN
    assign oEVT_LAST    = last_r;
`endif

endmodule
